spi_master_word_seq: RTL
========================

Name: spi_master_word_seq

Overview:
- Host-side sequencer feeding the byte-level SPI master engine, which transfers exactly one byte per enable cycle.
- Accepts 1–4 byte words from the processor bus and splits them into MSB-first bytes.
- Drives the engine's write data, enable and chip-select, and reassembles received bytes into a 32-bit response.
- Holds CS low across chained words so multi-word flash/PSRAM commands form one SPI frame.

Parameters:
- pCsSetup, 4: sysclk cycles with CS low before the first byte of a frame.
- pCsHold, 4: sysclk cycles after the last byte before CS is released high.
- pTimeout, 1024: sysclk cycles allowed per byte for iMSpiIntr; 10-bit counter minimum.

Ports:
- iSysClk  in  1  system clock
- iSysRstn  in  1  synchronous, active-low reset; one clock, sampled on iSysClk rising edge
- iMSSel  in  1  master/slave select from engine; 0 = FPGA master (block enabled), 1 = slave
- iReqValid  in  1  request valid
- oReqReady  out  1  request accepted when iReqValid & oReqReady
- iReqWd  in  32  write word; byte 0 = bits [31:24]
- iReqLen  in  3  byte count 1..4; 0 and 5..7 treated as 4
- iReqLast  in  1  1 = release CS after this word; 0 = keep frame open
- oRspValid  out  1  one-cycle pulse, read word complete
- oRspRd  out  32  received bytes right-justified, first byte highest
- oRspErr  out  1  valid with oRspValid; timeout or mode abort
- oBusy  out  1  high whenever CS is low or the FSM is not IDLE
- oMWd  out  8  byte to engine
- oSPIEn  out  1  engine enable; low reloads oMWd into engine shifter
- iMSpiIntr  in  1  engine byte-done pulse
- iMRd  in  8  engine received byte
- oMSPICs  out  1  chip select, active low

Behaviour:
- Reset (iSysRstn=0) values:
  - oReqReady=0, oRspValid=0, oRspErr=0, oRspRd=0, oBusy=0
  - oMWd=0, oSPIEn=0, oMSPICs=1
  - FSM=IDLE; all counters 0
- Reset mid-transfer: CS goes high the next edge; no response is issued.
- FSM states: IDLE, SETUP, LOAD, SHIFT, CAPT, OPEN, HOLD.
- IDLE:
  - oReqReady = ~iMSSel.
  - On accept: latch word, count = len, rd = 0, drive CS low, go to SETUP.
- SETUP: wait pCsSetup cycles, then go to LOAD.
- LOAD:
  - oSPIEn=0, oMWd = word[31:24]; one cycle; go to SHIFT.
  - The engine reloads its shifter only while enable is low, so LOAD is mandatory before every byte.
- SHIFT:
  - oSPIEn=1; wait for iMSpiIntr, then go to CAPT.
  - Timeout counter resets on entry.
- CAPT (one cycle, oSPIEn=0):
  - rd = {rd[23:0], iMRd}; word <<= 8; count -= 1.
  - iMRd is sampled the cycle after the intr pulse, never on it.
  - count≠0 → LOAD.
  - count=0:
    - oRspValid pulse next cycle with oRspRd=rd, oRspErr=0.
    - If iReqLast → HOLD, else → OPEN.
- OPEN:
  - CS stays low; oReqReady=1.
  - On accept: latch new word, go to LOAD with no setup delay.
  - iReqLast of a chained word is honoured as above.
- HOLD: wait pCsHold cycles, drive CS high, go to IDLE.
  - oReqReady=0 throughout HOLD, so a new frame always restarts with SETUP.
- Width rule: fewer than 4 bytes yields a right-justified result, e.g. len=2 → oRspRd[31:16]=0.
- Timeout: SHIFT exceeds pTimeout cycles →
  - oSPIEn=0;
  - oRspValid pulse with oRspErr=1 and partial rd;
  - go to HOLD.
- Mode abort: iMSSel rising while not IDLE → same as timeout.
  - If iMSSel=1 in OPEN with no request, go to HOLD without a response.
- Simultaneous events:
  - iMSpiIntr in the same cycle as timeout expiry: intr wins.
  - iMSSel rising in the same cycle as accept: request not accepted.
- oBusy = (FSM≠IDLE) | ~oMSPICs.

Decomposition:
- Shared package spi_pkg holds:
  - FSM state encoding (3-bit localparams);
  - pCsSetup/pCsHold/pTimeout defaults;
  - byte-length decode rule (0,5..7→4).
- One natural sub-module: spi_cycle_timer.
  - Loadable down-counter with a done flag.
  - Shared by SETUP, HOLD and the SHIFT timeout.
- Everything else stays in a single file, roughly 200 RTL lines.

Test Plan:
- Single 4-byte word: iReqWd=32'hA5C3_0F81, len=4, last=1, engine model echoes the complement.
  - Bytes A5,C3,0F,81 appear on oMWd, each preceded by ≥1 cycle of oSPIEn=0.
  - oRspRd=32'h5A3C_F07E.
  - CS low for pCsSetup+transfer+pCsHold cycles.
- Chained frame: word0 len=1 0x03 last=0, then word1 len=3 0x00123400 last=1.
  - Exactly 4 bytes 03,00,12,34 go out.
  - CS stays low continuously and never toggles between words.
  - Two oRspValid pulses.
- Short length: len=2 with the engine returning 0xBE, 0xEF.
  - oRspRd=32'h0000_BEEF; len=0 sends 4 bytes.
- Timeout: engine never pulses intr on byte 2 of a 4-byte word.
  - After pTimeout cycles: oRspErr=1, oRspRd=32'h0000_00xx (byte 1).
  - CS high after pCsHold; oReqReady returns to 1.
- Mode/reset: iMSSel=1 in IDLE → oReqReady=0, CS stays 1.
  - iSysRstn=0 pulsed during SHIFT → next cycle oMSPICs=1, oSPIEn=0, no oRspValid.
- Back-to-back: iReqValid held high with 3 chained words.
  - Exactly one accept per word, occurring in IDLE/OPEN only.

Source files
------------

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared state encoding, timing defaults and length decode for the SPI word sequencer
package spi_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_LOAD  = 3'd2,
    S_SHIFT = 3'd3,
    S_CAPT  = 3'd4,
    S_OPEN  = 3'd5,
    S_HOLD  = 3'd6
  } seq_state_t;

  localparam int P_CS_SETUP = 4;
  localparam int P_CS_HOLD  = 4;
  localparam int P_TIMEOUT  = 1024;
  localparam int TMR_W      = 11;

  // Out-of-range lengths (0, 5..7) fall back to a full 4-byte word.
  function automatic logic [2:0] decode_len(input logic [2:0] len);
    return ((len >= 3'd1) && (len <= 3'd4)) ? len : 3'd4;
  endfunction

endpackage

// File: rtl/spi_cycle_timer.sv
// rtl/spi_cycle_timer.sv - loadable down-counter; done while the count sits at zero
module spi_cycle_timer
  import spi_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_load,
  input  logic [TMR_W-1:0] i_load_val,
  output logic             o_done
);

  logic [TMR_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - TMR_W'(1);
    end
  end

  assign o_done = (r_cnt == '0);

endmodule

// File: rtl/spi_master_word_seq.sv
// rtl/spi_master_word_seq.sv - splits 1-4 byte bus words into SPI engine bytes and reassembles replies
// CS stays low across chained words so one command can span several requests.
module spi_master_word_seq
  import spi_pkg::*;
#(
  parameter int pCsSetup = P_CS_SETUP,
  parameter int pCsHold  = P_CS_HOLD,
  parameter int pTimeout = P_TIMEOUT
) (
  input  logic        iSysClk,
  input  logic        iSysRstn,
  input  logic        iMSSel,
  input  logic        iReqValid,
  output logic        oReqReady,
  input  logic [31:0] iReqWd,
  input  logic [2:0]  iReqLen,
  input  logic        iReqLast,
  output logic        oRspValid,
  output logic [31:0] oRspRd,
  output logic        oRspErr,
  output logic        oBusy,
  output logic [7:0]  oMWd,
  output logic        oSPIEn,
  input  logic        iMSpiIntr,
  input  logic [7:0]  iMRd,
  output logic        oMSPICs
);

  seq_state_t       r_state;
  logic [31:0]      r_word;
  logic [23:0]      r_rd;
  logic [2:0]       r_count;
  logic             r_last;
  logic             r_cs;
  logic             r_en;
  logic [7:0]       r_mwd;
  logic             r_mssel_q;
  logic             r_rsp_valid;
  logic             r_rsp_err;
  logic [31:0]      r_rsp_rd;

  logic             w_accept;
  logic             w_active;
  logic             w_abort;
  logic             w_timeout;
  logic             w_open_quit;
  logic             w_last_capt;
  logic             w_to_hold;
  logic             w_tmr_done;
  logic             w_tmr_load;
  logic [TMR_W-1:0] w_tmr_val;
  logic [31:0]      w_rd_next;

  // Ready is combinational so a same-cycle iMSSel rise blocks the handshake.
  assign oReqReady   = iSysRstn & ~iMSSel & ((r_state == S_IDLE) | (r_state == S_OPEN));
  assign w_accept    = iReqValid & oReqReady;
  assign w_active    = (r_state == S_SETUP) | (r_state == S_LOAD) |
                       (r_state == S_SHIFT) | (r_state == S_CAPT);
  assign w_abort     = w_active & iMSSel & ~r_mssel_q;
  assign w_timeout   = (r_state == S_SHIFT) & ~iMSpiIntr & w_tmr_done;
  assign w_open_quit = (r_state == S_OPEN) & iMSSel;
  assign w_last_capt = (r_state == S_CAPT) & (r_count == 3'd1);
  assign w_to_hold   = w_abort | w_timeout | w_open_quit | (w_last_capt & r_last);
  assign w_rd_next   = {r_rd, iMRd};

  always_comb begin
    w_tmr_load = 1'b0;
    w_tmr_val  = '0;
    if (w_to_hold) begin
      w_tmr_load = 1'b1;
      w_tmr_val  = TMR_W'(pCsHold - 1);
    end else if ((r_state == S_IDLE) && w_accept) begin
      w_tmr_load = 1'b1;
      w_tmr_val  = TMR_W'(pCsSetup - 1);
    end else if (r_state == S_LOAD) begin
      w_tmr_load = 1'b1;
      w_tmr_val  = TMR_W'(pTimeout - 1);
    end
  end

  spi_cycle_timer u_timer (
    .i_clk      (iSysClk),
    .i_rstn     (iSysRstn),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_done     (w_tmr_done)
  );

  always_ff @(posedge iSysClk) begin
    if (!iSysRstn) begin
      r_state     <= S_IDLE;
      r_word      <= '0;
      r_rd        <= '0;
      r_count     <= '0;
      r_last      <= 1'b0;
      r_cs        <= 1'b1;
      r_en        <= 1'b0;
      r_mwd       <= '0;
      r_mssel_q   <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rd    <= '0;
    end else begin
      r_mssel_q   <= iMSSel;
      r_rsp_valid <= 1'b0;
      if (w_abort) begin
        r_en        <= 1'b0;
        r_rsp_valid <= 1'b1;
        r_rsp_err   <= 1'b1;
        r_rsp_rd    <= {8'h00, r_rd};
        r_state     <= S_HOLD;
      end else begin
        case (r_state)
          S_IDLE: if (w_accept) begin
            r_word  <= iReqWd;
            r_count <= decode_len(iReqLen);
            r_last  <= iReqLast;
            r_rd    <= '0;
            r_cs    <= 1'b0;
            r_state <= S_SETUP;
          end
          S_SETUP: if (w_tmr_done) begin
            r_mwd   <= r_word[31:24];
            r_state <= S_LOAD;
          end
          S_LOAD: begin
            r_en    <= 1'b1;
            r_state <= S_SHIFT;
          end
          // A byte-done pulse on the expiry cycle still counts as a completed byte.
          S_SHIFT: if (iMSpiIntr) begin
            r_en    <= 1'b0;
            r_state <= S_CAPT;
          end else if (w_tmr_done) begin
            r_en        <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b1;
            r_rsp_rd    <= {8'h00, r_rd};
            r_state     <= S_HOLD;
          end
          S_CAPT: begin
            r_rd    <= w_rd_next[23:0];
            r_word  <= {r_word[23:0], 8'h00};
            r_count <= r_count - 3'd1;
            if (r_count == 3'd1) begin
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b0;
              r_rsp_rd    <= w_rd_next;
              r_state     <= r_last ? S_HOLD : S_OPEN;
            end else begin
              r_mwd   <= r_word[23:16];
              r_state <= S_LOAD;
            end
          end
          S_OPEN: if (iMSSel) begin
            r_state <= S_HOLD;
          end else if (w_accept) begin
            r_word  <= iReqWd;
            r_count <= decode_len(iReqLen);
            r_last  <= iReqLast;
            r_rd    <= '0;
            r_mwd   <= iReqWd[31:24];
            r_state <= S_LOAD;
          end
          S_HOLD: if (w_tmr_done) begin
            r_cs    <= 1'b1;
            r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign oRspValid = r_rsp_valid;
  assign oRspRd    = r_rsp_rd;
  assign oRspErr   = r_rsp_err;
  assign oMWd      = r_mwd;
  assign oSPIEn    = r_en;
  assign oMSPICs   = r_cs;
  assign oBusy     = (r_state != S_IDLE) | ~r_cs;

endmodule
